// File: rtl/fb_pkg.sv
// Shared constants, colours and state encoding for the framebuffer writer.
// Also hosts the round-robin index helper used by the arbiter.
package fb_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 128;
    localparam int NPIX     = SCREEN_W * SCREEN_H;

    localparam logic [2:0] COLOR_FONDO = 3'b001;
    localparam logic [2:0] COLOR_BARRA = 3'b010;
    localparam logic [2:0] COLOR_BOLA  = 3'b111;
    localparam logic [2:0] ROJO        = 3'b100;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } fb_state_t;

    // Requester visited at search step k: (last + 1 + k) mod 3.
    function automatic logic [1:0] rr_idx(
        input logic [1:0] last,
        input logic [1:0] k
    );
        logic [2:0] s;
        s = {1'b0, last} + {1'b0, k} + 3'd1;
        if (s >= 3'd6)
            s = s - 3'd6;
        else if (s >= 3'd3)
            s = s - 3'd3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester, clear-control and framebuffer write signals of the arbiter.
// master = client side, slave = arbiter side.
interface fb_write_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 3
);
    logic [2:0]    req;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [2:0]    ack;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic          clr_done;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic          err_oob;

    modport master (
        output req, addr0, addr1, addr2,
        output data0, data1, data2,
        output clr_start, clr_color,
        input  ack, clr_busy, clr_done,
        input  mem_px_addr, mem_px_data,
        input  px_wr, err_oob
    );

    modport slave (
        input  req, addr0, addr1, addr2,
        input  data0, data1, data2,
        input  clr_start, clr_color,
        output ack, clr_busy, clr_done,
        output mem_px_addr, mem_px_data,
        output px_wr, err_oob
    );

endinterface

// File: rtl/fb_write_arbiter_rr_arb3.sv
// Three-way round-robin picker: first eligible requester
// starting from the one after the last grant.
module rr_arb3
    import fb_pkg::*;
(
    input  logic [2:0] elig,
    input  logic [1:0] last,
    output logic [1:0] gnt,
    output logic       vld
);

    logic [3:0] e;

    assign e = {1'b0, elig};

    // Scan backwards so the earliest position in the rotation wins.
    always_comb begin
        gnt = 2'd0;
        vld = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (e[rr_idx(last, 2'(k))]) begin
                gnt = rr_idx(last, 2'(k));
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: round-robin pixel writes from three
// clients plus a full-screen fill engine; all outputs registered.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int AW = 15,
    parameter int DW = 3
) (
    input  logic clk,
    input  logic rst,
    fb_write_arbiter_if.slave bus
);

    localparam logic [AW-1:0] NPIX_A   = AW'(NPIX);
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

    fb_state_t     state, state_nxt;
    logic [1:0]    last, last_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] color, color_nxt;

    logic [2:0]    ack_q, ack_nxt;
    logic          wr_q, wr_nxt;
    logic          oob_q, oob_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [DW-1:0] data_q, data_nxt;

    logic [2:0]    elig;
    logic [1:0]    gnt;
    logic          vld;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // A requester acked this cycle is still showing its old req.
    assign elig = bus.req & ~ack_q;

    rr_arb3 u_rr (
        .elig (elig),
        .last (last),
        .gnt  (gnt),
        .vld  (vld)
    );

    always_comb begin
        sel_addr = bus.addr0;
        sel_data = bus.data0;
        unique case (gnt)
            2'd1: begin
                sel_addr = bus.addr1;
                sel_data = bus.data1;
            end
            2'd2: begin
                sel_addr = bus.addr2;
                sel_data = bus.data2;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        color_nxt = color;
        ack_nxt   = 3'b000;
        wr_nxt    = 1'b0;
        oob_nxt   = 1'b0;
        done_nxt  = 1'b0;
        busy_nxt  = busy_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        unique case (state)
            ARB: begin
                if (bus.clr_start) begin
                    state_nxt = CLEAR;
                    color_nxt = bus.clr_color;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else if (vld) begin
                    ack_nxt  = 3'b001 << gnt;
                    last_nxt = gnt;
                    if (sel_addr >= NPIX_A) begin
                        oob_nxt = 1'b1;
                    end else begin
                        wr_nxt   = 1'b1;
                        addr_nxt = sel_addr;
                        data_nxt = sel_data;
                    end
                end
            end
            CLEAR: begin
                wr_nxt   = 1'b1;
                addr_nxt = cnt;
                data_nxt = color;
                if (cnt == LAST_PIX)
                    state_nxt = DONE;
                else
                    cnt_nxt = cnt + 1'b1;
            end
            DONE: begin
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ARB;
            last   <= 2'd2;
            cnt    <= '0;
            color  <= '0;
            ack_q  <= '0;
            wr_q   <= 1'b0;
            oob_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            last   <= last_nxt;
            cnt    <= cnt_nxt;
            color  <= color_nxt;
            ack_q  <= ack_nxt;
            wr_q   <= wr_nxt;
            oob_q  <= oob_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.px_wr       = wr_q;
    assign bus.err_oob     = oob_q;
    assign bus.clr_busy    = busy_q;
    assign bus.clr_done    = done_q;
    assign bus.mem_px_addr = addr_q;
    assign bus.mem_px_data = data_q;

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter AW, default 15, meaning the pixel address width.
REQ-002 SHALL have parameter DW, default 3, meaning the pixel colour width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 3 bits: per-requester write request (0=paddle, 1=ball, 2=overlay).
REQ-006 SHALL have ports addr0, addr1, addr2, each input, AW bits: the requested pixel address, equal to x+y*160.
REQ-007 SHALL have ports data0, data1, data2, each input, DW bits: the requested pixel colour.
REQ-008 SHALL have port ack, output, 3 bits: a one-cycle pulse that consumes the pending request.
REQ-009 SHALL have port clr_start, input, 1 bit: a pulse requesting a full-screen fill.
REQ-010 SHALL have port clr_color, input, DW bits: the fill colour, sampled with clr_start.
REQ-011 SHALL have port clr_busy, output, 1 bit: high while the fill is in progress.
REQ-012 SHALL have port clr_done, output, 1 bit: a one-cycle pulse when the fill completes.
REQ-013 SHALL have port mem_px_addr, output, AW bits: the framebuffer write address.
REQ-014 SHALL have port mem_px_data, output, DW bits: the framebuffer write data.
REQ-015 SHALL have port px_wr, output, 1 bit: the framebuffer write strobe.
REQ-016 SHALL have port err_oob, output, 1 bit: a one-cycle pulse when an out-of-range address is dropped.

Function
REQ-017 SHALL implement the states ARB, CLEAR and DONE.
REQ-018 SHALL make all outputs registered.
REQ-019 SHALL hold px_wr, ack, clr_done and err_oob low in any cycle that carries no event for them.
REQ-020 In ARB, SHALL select at each edge one eligible requester, searching round-robin from (last_grant+1) mod 3.
REQ-021 SHALL treat requester i as eligible when req[i]=1 and ack[i] is not currently high; a requester being acked is masked for one cycle.
REQ-022 On a grant to requester i at edge k, SHALL drive at edge k: ack[i]=1, px_wr=1, mem_px_addr=addr_i, mem_px_data=data_i, last_grant=i.
REQ-023 SHALL have a latency of one edge from req sampled high to write and ack.
REQ-024 SHALL provide aggregate throughput of 1 write/cycle when at least 2 requesters are active, and 1 write/2 cycles for a single requester.
REQ-025 SHALL treat addr_i >= 20480 as out of range: ack[i]=1 and err_oob=1 are issued, and px_wr stays 0.
REQ-026 On clr_start=1 in ARB, SHALL enter CLEAR at the next edge, latch clr_color, set clr_busy=1 and issue no grant that cycle.
REQ-027 SHALL give clr_start priority over any simultaneous req.
REQ-028 In CLEAR, SHALL write addr 0,1,...,20479 one per cycle with px_wr=1 and the latched colour, taking 20480 cycles.
REQ-029 SHALL assert no ack during CLEAR; pending reqs SHALL simply wait.
REQ-030 SHALL ignore clr_start while in CLEAR or DONE.
REQ-031 After writing address 20479, SHALL enter DONE with clr_busy=0 and px_wr=0.
REQ-032 In DONE, SHALL pulse clr_done=1 for one cycle and then return to ARB.
REQ-033 SHALL resume arbitration in ARB with last_grant unchanged from before the clear.
REQ-034 SHALL perform all address arithmetic unsigned in AW bits; the fill counter SHALL stop at 20479 and never wrap.

Reset
REQ-035 When rst=0, SHALL asynchronously force: state=ARB, last_grant=2 (so requester 0 wins first), fill counter=0, and every output to 0.
REQ-036 SHALL treat a reset during CLEAR as an abort: no clr_done pulse, and the partial fill is left in memory.
REQ-037 After rst rises, the first grant SHALL occur no earlier than the first following edge.

Structure
REQ-038 SHALL place in shared package fb_pkg: SCREEN_W=160, SCREEN_H=128, NPIX=20480, the colour constants (COLOR_FONDO=001, COLOR_BARRA=010, COLOR_BOLA=111, ROJO=100) and the state encoding.
REQ-039 SHALL implement round-robin selection as the sub-module rr_arb3 (inputs: eligible vector and last_grant; outputs: grant index and valid); the remainder stays in fb_write_arbiter.

Verification
REQ-040 Reset, then req=001 with addr0=15280, data0=010 held -> px_wr every 2nd cycle, addr 15280, ack[0] alternating; first write on the first edge after the req is sampled.
REQ-041 req=111 held, addrs 100/200/300 -> write order 100, 200, 300, 100, ... at 1 write/cycle; each ack aligned with its write.
REQ-042 req=010 with addr1=20480 -> ack[1]=1, err_oob=1, px_wr=0 in the same cycle.
REQ-043 clr_start with clr_color=001 together with req=001 -> no ack[0]; 20480 writes at addresses 0..20479 with data 001; clr_busy high throughout; clr_done one cycle later; then ack[0] is granted.
REQ-044 rst=0 asserted mid-clear at address 5000 -> all outputs 0 immediately with no clock edge; no clr_done; after release the arbiter is in ARB.
REQ-045 clr_start pulsed again during CLEAR -> ignored; exactly one clr_done; total of 20480 writes.
